operand_mux_pipe: RTL and testbench
===================================

# operand_mux_pipe

Parametrised, registered N-way word selector for the MIPS datapath; the successor to the combinational ALU-source mux. It picks one of `NUM_IN` operand words by a select code and registers the result behind a valid/ready handshake with a two-entry skid buffer, so stalls downstream never drop or duplicate an operand. It sits between the register-file/immediate/constant sources and the ALU input stage, one instance per ALU operand.

## Interface
- `NUM_IN`, 8: number of word inputs; 2..16.
- `WIDTH`, 32: word width in bits.
- `SEL_W`, $clog2(NUM_IN): select width; derived, not overridden.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of all buffered words.
- `in_valid`  in  1  select/data presented this cycle.
- `in_ready`  out  1  block can accept this cycle.
- `select`  in  SEL_W  input index.
- `data_in`  in  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- `out_valid`  out  1  `word` holds a selected operand.
- `out_ready`  in  1  consumer accepts `word`.
- `word`  out  WIDTH  selected operand, registered.
- `sel_err`  out  1  sticky out-of-range flag; exists only with `OPERAND_MUX_SEL_ERR_EN`.

## Operation
- Accept when `in_valid && in_ready`. Captured value is `data_in` slice `select`. If `select >= NUM_IN`, the captured value is all zeros.
- Storage: a main register (drives `word`) and a skid register.
- States:
  - EMPTY: nothing held.
  - ONE: main register valid.
  - FULL: main and skid registers valid.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept + consume → ONE, with the new word in main.
  - ONE + accept, no consume → FULL, new word in skid.
  - ONE + consume only → EMPTY.
  - FULL + consume → ONE, skid moves to main.
  - FULL: no accept is possible.
- `in_ready` = state != FULL. It is registered and depends only on state, never combinationally on `out_ready`.
- `out_valid` = state != EMPTY. Consume = `out_valid && out_ready`.
- Order is strictly preserved. Each accepted word is presented exactly once.
- `flush`: next state is EMPTY and both valid bits clear. A word accepted in the same cycle is discarded. Flush has priority over accept and consume.
- `word` holds its last value while `out_valid` = 0. It changes only on a main-register load.

## Timing
- Latency is 1 cycle: a word accepted at edge n is on `word` with `out_valid` = 1 after edge n.
- Throughput is 1 word/cycle while `out_ready` stays high.
- Reset (`reset_n` low, asynchronous):
  - Outputs: `out_valid` = 0, `in_ready` = 1, `word` = 0, `sel_err` = 0.
  - State: EMPTY, skid register = 0.
- Reset asserted mid-transfer discards all held words immediately. The first accept is possible on the first edge after `reset_n` rises.
- Back-pressure: `out_ready` low for k ≥ 2 cycles from ONE → one more accept, then `in_ready` = 0 until a consume.

## Configuration
- `OPERAND_MUX_SEL_ERR_EN` defined:
  - `sel_err` port present.
  - Sets on any accept with `select >= NUM_IN`.
  - Stays set until `reset_n`; `flush` does not clear it.
- Undefined: no port, no flag logic. Out-of-range selects still yield a zero word.

## Structure
- Shared package `operand_mux_pkg` holds:
  - state enum `mux_state_t` {EMPTY, ONE, FULL}, 2 bits;
  - `MUX_NUM_IN_MAX` = 16;
  - localparams for the datapath's source indices: REG = 0, IMM = 1, SHAMT = 2, CONST16 = 3, CONST2 = 4, PC = 5.
- One natural sub-module, `word_select`: purely combinational index-to-word picker with zero fill on out-of-range. Instantiated once at the capture point.

## Test plan
- Reset then single transfer: select = 3, input 3 = 0x0000_0010, `out_ready` = 1.
  - Required: `word` = 0x0000_0010 with `out_valid` = 1 one cycle after accept, then `out_valid` = 0.
- Streaming: selects 0..7 back-to-back, input k = 0xA0+k, `out_ready` held 1.
  - Required: eight consecutive valid cycles, 0xA0..0xA7 in order, `in_ready` never drops.
- Back-pressure: `out_ready` = 0 for 4 cycles while `in_valid` = 1 with words 0x11, 0x22, 0x33.
  - Required: 0x11 and 0x22 accepted, `in_ready` = 0 from the cycle after the second accept.
  - On release: 0x11, 0x22, then 0x33 emitted, no loss or duplicate.
- Out-of-range select with `NUM_IN` = 5, select = 6.
  - Required: `word` = 0.
  - With the macro defined: `sel_err` = 1, and it stays 1 through a later `flush`.
- Flush while FULL, with an accept in the same cycle.
  - Required: next cycle `out_valid` = 0, `in_ready` = 1, the accepted word never appears.
- Asynchronous reset mid-stream between clock edges.
  - Required: `out_valid` = 0 and `word` = 0 immediately, without waiting for an edge. A transfer after release behaves as in the first scenario.

Source files
------------

// File: rtl/operand_mux_pkg.sv
// ----------------------------------------------------------------------------
// operand_mux_pkg
// Shared definitions for the registered ALU operand selector:
//   - mux_state_t     : occupancy of the two-entry output buffer
//   - MUX_NUM_IN_MAX  : largest supported number of word inputs
//   - REG..PC         : datapath source indices used on the select code
// ----------------------------------------------------------------------------
package operand_mux_pkg;

    // Occupancy of the main/skid register pair.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,  // nothing held
        ONE   = 2'd1,  // main register valid
        FULL  = 2'd2   // main and skid registers valid
    } mux_state_t;

    localparam int MUX_NUM_IN_MAX = 16;

    // Operand source indices as wired in the MIPS datapath.
    localparam int REG     = 0;
    localparam int IMM     = 1;
    localparam int SHAMT   = 2;
    localparam int CONST16 = 3;
    localparam int CONST2  = 4;
    localparam int PC      = 5;

endpackage : operand_mux_pkg

// File: rtl/operand_mux_pipe_word_select.sv
// ----------------------------------------------------------------------------
// word_select
// Purely combinational index-to-word picker. Returns slice `select` of the
// flattened input bus, or all zeros when `select` is not below NUM_IN.
//
// Ports:
//   select        in  SEL_W         input index
//   data_in       in  NUM_IN*WIDTH  flattened words, word k at [k*WIDTH +: WIDTH]
//   word          out WIDTH         selected word (zero when out of range)
//   out_of_range  out 1             select >= NUM_IN
// ----------------------------------------------------------------------------
module word_select
    import operand_mux_pkg::*;
#(
    parameter int NUM_IN = 8,
    parameter int WIDTH  = 32,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [SEL_W-1:0]        select,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]        word,
    output logic                    out_of_range
);

    // One extra bit so NUM_IN itself is representable (e.g. 8 with SEL_W = 3).
    assign out_of_range = ({1'b0, select} >= (SEL_W + 1)'(NUM_IN));

    // NOTE: every output of an always_comb gets a default before any branch,
    // otherwise an unmatched select would infer a latch.
    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (select == SEL_W'(k)) begin
                word = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule : word_select

// File: rtl/operand_mux_pipe.sv
// ----------------------------------------------------------------------------
// operand_mux_pipe
// Registered N-way operand selector for one ALU operand. Picks data_in slice
// `select` on accept and holds it in a two-entry (main + skid) buffer behind a
// valid/ready handshake, so downstream stalls never drop or repeat a word.
// in_ready is decoded from the state register only; it never depends
// combinationally on out_ready.
//
// Optional feature macro: OPERAND_MUX_SEL_ERR_EN adds the sticky sel_err port.
//
// Ports:
//   clk        in  1             rising-edge clock
//   reset_n    in  1             asynchronous active-low reset
//   flush      in  1             synchronous clear of all buffered words
//   in_valid   in  1             select/data presented this cycle
//   in_ready   out 1             block can accept this cycle
//   select     in  SEL_W         input index
//   data_in    in  NUM_IN*WIDTH  flattened inputs, word k at [k*WIDTH +: WIDTH]
//   out_valid  out 1             word holds a selected operand
//   out_ready  in  1             consumer accepts word
//   word       out WIDTH         selected operand (main register)
//   sel_err    out 1             sticky out-of-range flag (macro only)
// ----------------------------------------------------------------------------
module operand_mux_pipe
    import operand_mux_pkg::*;
#(
    parameter int NUM_IN = 8,
    parameter int WIDTH  = 32,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        select,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        word
`ifdef OPERAND_MUX_SEL_ERR_EN
    ,
    output logic                    sel_err
`endif
);

    mux_state_t       state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] sel_word;
    logic             sel_oor;
    logic             accept;
    logic             consume;

    word_select #(
        .NUM_IN (NUM_IN),
        .WIDTH  (WIDTH),
        .SEL_W  (SEL_W)
    ) u_word_select (
        .select       (select),
        .data_in      (data_in),
        .word         (sel_word),
        .out_of_range (sel_oor)
    );

    // Both handshake outputs are pure decodes of the state register.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign word      = main_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order. The data
    // registers are reset too, since word and the skid contents are required
    // to read zero out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            // Dropping the valid state is enough; main_q keeps its value so
            // word only ever changes on a real main-register load.
            state <= EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= sel_word;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_q <= sel_word;
                    end else if (accept) begin
                        skid_q <= sel_word;
                        state  <= FULL;
                    end else if (consume) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a consume can happen.
                    if (consume) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef OPERAND_MUX_SEL_ERR_EN
    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err <= 1'b0;
        end else if (accept && sel_oor) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule : operand_mux_pipe

// File: tb/tb_operand_mux_pipe.sv
// ----------------------------------------------------------------------------
// tb_operand_mux_pipe
// Directed bench for operand_mux_pipe: an 8-input instance for the handshake
// scenarios and a 5-input instance for out-of-range selects.
// ----------------------------------------------------------------------------
module tb_operand_mux_pipe;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n;

    // 8-input instance
    logic          flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]    select;
    logic [8*W-1:0] data_in;
    logic [W-1:0]  word;

    // 5-input instance
    logic          flush5, in_valid5, in_ready5, out_valid5, out_ready5;
    logic [2:0]    select5;
    logic [5*W-1:0] data_in5;
    logic [W-1:0]  word5;

`ifdef OPERAND_MUX_SEL_ERR_EN
    logic sel_err, sel_err5;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    operand_mux_pipe #(.NUM_IN(8), .WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .select    (select),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word      (word)
`ifdef OPERAND_MUX_SEL_ERR_EN
        ,
        .sel_err   (sel_err)
`endif
    );

    operand_mux_pipe #(.NUM_IN(5), .WIDTH(W)) dut5 (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .select    (select5),
        .data_in   (data_in5),
        .out_valid (out_valid5),
        .out_ready (out_ready5),
        .word      (word5)
`ifdef OPERAND_MUX_SEL_ERR_EN
        ,
        .sel_err   (sel_err5)
`endif
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fill the 8-input bus with base+k in slice k.
    task automatic set_words(input logic [W-1:0] base);
        for (int k = 0; k < 8; k++) data_in[k*W +: W] = base + W'(k);
    endtask

    initial begin
        reset_n    = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        select     = '0;
        data_in    = '0;
        flush5     = 1'b0;
        in_valid5  = 1'b0;
        out_ready5 = 1'b1;
        select5    = '0;
        data_in5   = '0;

        // ---------------- reset state ----------------
        #2;
        check("rst_out_valid", W'(out_valid), 0);
        check("rst_in_ready",  W'(in_ready),  1);
        check("rst_word",      word,          0);
`ifdef OPERAND_MUX_SEL_ERR_EN
        check("rst_sel_err",   W'(sel_err),   0);
`endif
        tick();
        tick();
        reset_n = 1'b1;

        // ---------------- single transfer ----------------
        set_words(32'h0000_0F00);
        data_in[3*W +: W] = 32'h0000_0010;
        select    = 3'd3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        check("single_valid", W'(out_valid), 1);
        check("single_word",  word, 32'h0000_0010);
        in_valid = 1'b0;
        tick();
        check("single_drain_valid", W'(out_valid), 0);
        check("single_word_hold",   word, 32'h0000_0010);

        // ---------------- streaming ----------------
        set_words(32'h0000_00A0);
        for (int k = 0; k < 8; k++) begin
            select   = 3'(k);
            in_valid = 1'b1;
            check($sformatf("stream_in_ready_%0d", k), W'(in_ready), 1);
            tick();
            check($sformatf("stream_valid_%0d", k), W'(out_valid), 1);
            check($sformatf("stream_word_%0d", k), word, 32'h0000_00A0 + W'(k));
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain_valid", W'(out_valid), 0);

        // ---------------- back-pressure ----------------
        out_ready = 1'b0;
        select    = 3'd0;
        in_valid  = 1'b1;
        data_in[0 +: W] = 32'h11;
        tick();                                   // accept 0x11 -> ONE
        check("bp_first_word",  word, 32'h11);
        check("bp_ready_after1", W'(in_ready), 1);
        data_in[0 +: W] = 32'h22;
        tick();                                   // accept 0x22 -> FULL
        check("bp_ready_after2", W'(in_ready), 0);
        check("bp_word_still_11", word, 32'h11);
        data_in[0 +: W] = 32'h33;
        tick();
        tick();                                   // fourth stalled cycle
        check("bp_ready_stall", W'(in_ready), 0);
        check("bp_valid_stall", W'(out_valid), 1);
        check("bp_word_stall",  word, 32'h11);
        out_ready = 1'b1;                         // 0x11 consumed on next edge
        tick();
        check("bp_rel_word_22", word, 32'h22);
        check("bp_rel_ready",   W'(in_ready), 1);
        tick();                                   // 0x22 out, 0x33 in
        check("bp_rel_word_33", word, 32'h33);
        check("bp_rel_valid_33", W'(out_valid), 1);
        in_valid = 1'b0;
        tick();
        check("bp_drain_valid", W'(out_valid), 0);

        // ---------------- flush while FULL ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in[0 +: W] = 32'h61;
        tick();
        data_in[0 +: W] = 32'h62;
        tick();
        check("fl_full_ready", W'(in_ready), 0);
        flush = 1'b1;
        data_in[0 +: W] = 32'h63;
        tick();
        check("fl_full_valid", W'(out_valid), 0);
        check("fl_full_ready_after", W'(in_ready), 1);
        // flush in ONE with a real accept in the same cycle
        flush = 1'b0;
        data_in[0 +: W] = 32'h71;
        tick();                                   // ONE holding 0x71
        flush = 1'b1;
        data_in[0 +: W] = 32'h72;                 // accepted but discarded
        tick();
        check("fl_one_valid", W'(out_valid), 0);
        check("fl_one_ready", W'(in_ready), 1);
        check("fl_one_word_hold", word, 32'h71);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("fl_discard_valid", W'(out_valid), 0);
        check("fl_discard_word",  word, 32'h71);

        // ---------------- out-of-range select (NUM_IN = 5) ----------------
        for (int k = 0; k < 5; k++) data_in5[k*W +: W] = 32'hC0 + W'(k);
        select5   = 3'd6;
        in_valid5 = 1'b1;
        tick();
        check("oor_valid", W'(out_valid5), 1);
        check("oor_word",  word5, 0);
`ifdef OPERAND_MUX_SEL_ERR_EN
        check("oor_sel_err", W'(sel_err5), 1);
`endif
        select5 = 3'd4;                           // last legal index
        tick();
        check("oor_edge_word", word5, 32'hC4);
        select5 = 3'd5;                           // first illegal index
        tick();
        check("oor_first_bad_word", word5, 0);
        in_valid5 = 1'b0;
        flush5    = 1'b1;
        tick();
        check("oor_flush_valid", W'(out_valid5), 0);
`ifdef OPERAND_MUX_SEL_ERR_EN
        check("oor_sel_err_sticky", W'(sel_err5), 1);
`endif
        flush5 = 1'b0;

        // ---------------- async reset mid-stream ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in[0 +: W] = 32'h81;
        tick();
        data_in[0 +: W] = 32'h82;
        tick();                                   // FULL
        in_valid = 1'b0;
        #2;                                       // between clock edges
        reset_n = 1'b0;
        #1;
        check("arst_valid", W'(out_valid), 0);
        check("arst_word",  word, 0);
        check("arst_ready", W'(in_ready), 1);
        tick();
        #2;
        reset_n = 1'b1;
        set_words(32'h0000_0F00);
        data_in[3*W +: W] = 32'h0000_0010;
        select    = 3'd3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        check("arst_single_valid", W'(out_valid), 1);
        check("arst_single_word",  word, 32'h0000_0010);
        in_valid = 1'b0;
        tick();
        check("arst_single_drain", W'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_operand_mux_pipe
